// File: rtl/oc8051_etr_bank_pkg.sv
// ============================================================================
// Module  : oc8051_etr_bank_pkg
// Purpose : SFR addresses, CTRL bit positions and staging-FSM encoding for
//           the ecall target register bank.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package oc8051_etr_bank_pkg;

  localparam logic [7:0] OC8051_SFR_ETR_IDX  = 8'hE9;
  localparam logic [7:0] OC8051_SFR_ETR_LO   = 8'hEA;
  localparam logic [7:0] OC8051_SFR_ETR_HI   = 8'hEB;
  localparam logic [7:0] OC8051_SFR_ETR_CTRL = 8'hEC;

  // CTRL readback layout
  localparam int ETR_CTRL_VALID  = 0;
  localparam int ETR_CTRL_LOCK   = 1;
  localparam int ETR_CTRL_STAGED = 2;
  localparam int ETR_CTRL_ERR    = 7;

  // CTRL write command bits
  localparam int C_ETR_CMD_LOCK    = 0;
  localparam int C_ETR_CMD_INVAL   = 1;
  localparam int C_ETR_CMD_CLR_ERR = 7;

  typedef enum logic [0:0] {
    ETR_IDLE   = 1'b0,
    ETR_STAGED = 1'b1
  } etr_state_e;

endpackage

`default_nettype wire

// File: rtl/oc8051_etr_entry.sv
// ============================================================================
// Module  : oc8051_etr_entry
// Purpose : One ecall target: 16-bit target with valid and sticky lock.
//           Also exposes the post-write view used for lookup forwarding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module oc8051_etr_entry (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit,
  input  logic [15:0] commit_data,
  input  logic        invalidate,
  input  logic        lock_set,
  output logic [15:0] target,
  output logic        valid,
  output logic        lock,
  output logic [15:0] target_nxt,
  output logic        valid_nxt,
  output logic        violation
);

  logic [15:0] r_target;
  logic        r_valid;
  logic        r_lock;

  always_comb begin
    target_nxt = r_target;
    valid_nxt  = r_valid;
    if (!r_lock) begin
      if (commit) begin
        target_nxt = commit_data;
        valid_nxt  = 1'b1;
      end else if (invalidate) begin
        valid_nxt  = 1'b0;
      end
    end
  end

  assign violation = (commit | invalidate) & r_lock;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_target <= 16'h0000;
      r_valid  <= 1'b0;
      r_lock   <= 1'b0;
    end else begin
      r_target <= target_nxt;
      r_valid  <= valid_nxt;
      if (lock_set) begin
        r_lock <= 1'b1;
      end
    end
  end

  assign target = r_target;
  assign valid  = r_valid;
  assign lock   = r_lock;

endmodule

`default_nettype wire

// File: rtl/oc8051_etr_bank.sv
// ============================================================================
// Module  : oc8051_etr_bank
// Purpose : Ecall target register bank with atomic LO/HI commit, per-entry
//           lock/valid and a one-cycle registered lookup port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module oc8051_etr_bank
  import oc8051_etr_bank_pkg::*;
#(
  parameter int         N_ENTRIES = 4,
  parameter logic [7:0] SFR_IDX   = OC8051_SFR_ETR_IDX,
  parameter logic [7:0] SFR_LO    = OC8051_SFR_ETR_LO,
  parameter logic [7:0] SFR_HI    = OC8051_SFR_ETR_HI,
  parameter logic [7:0] SFR_CTRL  = OC8051_SFR_ETR_CTRL,
  localparam int        IW        = $clog2(N_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          wr_bit,
  input  logic [7:0]    wr_addr,
  input  logic [7:0]    data_in,
  input  logic [7:0]    rd_addr,
  output logic [7:0]    data_out,
  output logic          rd_hit,
  input  logic          ecall_req,
  input  logic [IW-1:0] ecall_idx,
  output logic          ecall_ack,
  output logic [15:0]   ecall_target,
  output logic          ecall_fault
);

  etr_state_e    r_state;
  etr_state_e    w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_stage_lo;
  logic          r_err;
  logic          r_ack;
  logic [15:0]   r_target;
  logic          r_fault;

  logic w_wr_ok, w_wr_idx, w_wr_lo, w_wr_hi, w_wr_ctrl;
  logic w_commit, w_hi_idle, w_inval, w_lock_set, w_err_set;

  logic [15:0]          w_tgt     [N_ENTRIES];
  logic [15:0]          w_tgt_nxt [N_ENTRIES];
  logic [N_ENTRIES-1:0] w_vld;
  logic [N_ENTRIES-1:0] w_vld_nxt;
  logic [N_ENTRIES-1:0] w_lck;
  logic [N_ENTRIES-1:0] w_viol;

  assign w_wr_ok    = wr && !wr_bit;
  assign w_wr_idx   = w_wr_ok && (wr_addr == SFR_IDX);
  assign w_wr_lo    = w_wr_ok && (wr_addr == SFR_LO);
  assign w_wr_hi    = w_wr_ok && (wr_addr == SFR_HI);
  assign w_wr_ctrl  = w_wr_ok && (wr_addr == SFR_CTRL);

  assign w_commit   = w_wr_hi && (r_state == ETR_STAGED);
  assign w_hi_idle  = w_wr_hi && (r_state == ETR_IDLE);
  assign w_inval    = w_wr_ctrl && data_in[C_ETR_CMD_INVAL];
  assign w_lock_set = w_wr_ctrl && data_in[C_ETR_CMD_LOCK];
  assign w_err_set  = w_hi_idle || (|w_viol);

  always_comb begin
    w_state_nxt = r_state;
    if (w_wr_idx && (data_in[IW-1:0] != r_idx)) begin
      w_state_nxt = ETR_IDLE;
    end else if (w_wr_lo) begin
      w_state_nxt = ETR_STAGED;
    end else if (w_wr_hi) begin
      w_state_nxt = ETR_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ETR_IDLE;
      r_idx      <= '0;
      r_stage_lo <= 8'h00;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_idx) begin
        r_idx <= data_in[IW-1:0];
      end
      if (w_wr_lo) begin
        r_stage_lo <= data_in;
      end
      // A new error wins over a simultaneous clear request.
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_wr_ctrl && data_in[C_ETR_CMD_CLR_ERR]) begin
        r_err <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_entry
    logic w_sel;
    assign w_sel = (r_idx == IW'(gi));

    oc8051_etr_entry u_entry (
      .clk         (clk),
      .rst         (rst),
      .commit      (w_commit && w_sel),
      .commit_data ({data_in, r_stage_lo}),
      .invalidate  (w_inval && w_sel),
      .lock_set    (w_lock_set && w_sel),
      .target      (w_tgt[gi]),
      .valid       (w_vld[gi]),
      .lock        (w_lck[gi]),
      .target_nxt  (w_tgt_nxt[gi]),
      .valid_nxt   (w_vld_nxt[gi]),
      .violation   (w_viol[gi])
    );
  end

  // Lookup reads the post-write view so a same-cycle commit is forwarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack    <= 1'b0;
      r_target <= 16'h0000;
      r_fault  <= 1'b0;
    end else begin
      r_ack <= ecall_req;
      if (ecall_req) begin
        r_target <= w_tgt_nxt[ecall_idx];
        r_fault  <= !w_vld_nxt[ecall_idx];
      end
    end
  end

  assign ecall_ack    = r_ack;
  assign ecall_target = r_target;
  assign ecall_fault  = r_fault && r_ack;

  logic [7:0] w_ctrl_rd;
  logic [15:0] w_cur_tgt;

  assign w_cur_tgt = w_tgt[r_idx];

  always_comb begin
    w_ctrl_rd                  = 8'h00;
    w_ctrl_rd[ETR_CTRL_VALID]  = w_vld[r_idx];
    w_ctrl_rd[ETR_CTRL_LOCK]   = w_lck[r_idx];
    w_ctrl_rd[ETR_CTRL_STAGED] = (r_state == ETR_STAGED);
    w_ctrl_rd[ETR_CTRL_ERR]    = r_err;
  end

  always_comb begin
    data_out = 8'h00;
    rd_hit   = 1'b1;
    if (rd_addr == SFR_IDX) begin
      data_out = 8'(r_idx);
    end else if (rd_addr == SFR_LO) begin
      data_out = w_cur_tgt[7:0];
    end else if (rd_addr == SFR_HI) begin
      data_out = w_cur_tgt[15:8];
    end else if (rd_addr == SFR_CTRL) begin
      data_out = w_ctrl_rd;
    end else begin
      rd_hit   = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_oc8051_etr_bank.sv
// ============================================================================
// Module  : tb_oc8051_etr_bank
// Purpose : Directed plus randomized bench with a behavioural bank model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oc8051_etr_bank;
  import oc8051_etr_bank_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam logic [7:0] A_IDX  = OC8051_SFR_ETR_IDX;
  localparam logic [7:0] A_LO   = OC8051_SFR_ETR_LO;
  localparam logic [7:0] A_HI   = OC8051_SFR_ETR_HI;
  localparam logic [7:0] A_CTRL = OC8051_SFR_ETR_CTRL;

  logic          clk = 1'b0;
  logic          rst, wr, wr_bit, rd_hit, ecall_req, ecall_ack, ecall_fault;
  logic [7:0]    wr_addr, data_in, rd_addr, data_out;
  logic [IW-1:0] ecall_idx;
  logic [15:0]   ecall_target;

  oc8051_etr_bank #(.N_ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .wr(wr), .wr_bit(wr_bit), .wr_addr(wr_addr),
    .data_in(data_in), .rd_addr(rd_addr), .data_out(data_out), .rd_hit(rd_hit),
    .ecall_req(ecall_req), .ecall_idx(ecall_idx), .ecall_ack(ecall_ack),
    .ecall_target(ecall_target), .ecall_fault(ecall_fault)
  );

  always #5 clk = ~clk;

  // Behavioural model of the bank
  logic [15:0] m_ent [N];
  logic        m_vld [N];
  logic        m_lck [N];
  int          m_idx;
  logic        m_staged;
  logic [7:0]  m_lo;
  logic        m_err;
  logic        e_ack;
  logic [15:0] e_tgt;
  logic        e_flt;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_ent[i] = 16'h0; m_vld[i] = 1'b0; m_lck[i] = 1'b0;
    end
    m_idx = 0; m_staged = 1'b0; m_lo = 8'h0; m_err = 1'b0;
    e_ack = 1'b0; e_tgt = 16'h0; e_flt = 1'b0;
  endtask

  task automatic m_write(input logic [7:0] a, input logic [7:0] d);
    logic e;
    e = 1'b0;
    if (a == A_IDX) begin
      if ((d % N) != m_idx) m_staged = 1'b0;
      m_idx = d % N;
    end else if (a == A_LO) begin
      m_lo = d; m_staged = 1'b1;
    end else if (a == A_HI) begin
      if (!m_staged) e = 1'b1;
      else if (m_lck[m_idx]) e = 1'b1;
      else begin
        m_ent[m_idx] = {d, m_lo}; m_vld[m_idx] = 1'b1;
      end
      m_staged = 1'b0;
    end else if (a == A_CTRL) begin
      if (d[1]) begin
        if (m_lck[m_idx]) e = 1'b1;
        else m_vld[m_idx] = 1'b0;
      end
      if (d[0]) m_lck[m_idx] = 1'b1;
      if (d[7]) m_err = 1'b0;
    end
    if (e) m_err = 1'b1;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (a == A_IDX)  return 8'(m_idx);
    if (a == A_LO)   return m_ent[m_idx][7:0];
    if (a == A_HI)   return m_ent[m_idx][15:8];
    if (a == A_CTRL) return {m_err, 4'b0, m_staged, m_lck[m_idx], m_vld[m_idx]};
    return 8'h00;
  endfunction

  // One clock: optional SFR write and optional lookup, then check lookup outputs.
  task automatic cyc(input logic w, input logic wb, input logic [7:0] a,
                     input logic [7:0] d, input logic rq, input int ri);
    wr = w; wr_bit = wb; wr_addr = a; data_in = d;
    ecall_req = rq; ecall_idx = IW'(ri);
    @(posedge clk); #1;
    wr = 1'b0; wr_bit = 1'b0; ecall_req = 1'b0;
    if (w && !wb) m_write(a, d);
    e_ack = rq;
    if (rq) begin
      e_tgt = m_ent[ri]; e_flt = !m_vld[ri];
    end else begin
      e_flt = 1'b0;
    end
    check("ack", 32'(ecall_ack), 32'(e_ack));
    check("target", 32'(ecall_target), 32'(e_tgt));
    check("fault", 32'(ecall_fault), 32'(e_flt));
  endtask

  task automatic wsfr(input logic [7:0] a, input logic [7:0] d);
    cyc(1'b1, 1'b0, a, d, 1'b0, 0);
  endtask

  task automatic rd(input logic [7:0] a, input string tag);
    rd_addr = a; #1;
    check({tag, "_data"}, 32'(data_out), 32'(m_read(a)));
    check({tag, "_hit"}, 32'(rd_hit),
          32'((a == A_IDX) || (a == A_LO) || (a == A_HI) || (a == A_CTRL)));
  endtask

  task automatic do_reset(input logic rq);
    rst = 1'b1; ecall_req = rq; ecall_idx = 2'd1; wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; ecall_req = 1'b0;
    m_reset();
    check("rst_ack", 32'(ecall_ack), 32'h0);
    check("rst_target", 32'(ecall_target), 32'h0);
    check("rst_fault", 32'(ecall_fault), 32'h0);
  endtask

  initial begin
    logic [7:0] a, d;
    rst = 1'b1; wr = 1'b0; wr_bit = 1'b0; wr_addr = 8'h0; data_in = 8'h0;
    rd_addr = 8'h0; ecall_req = 1'b0; ecall_idx = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);
    rd_addr = A_CTRL; #1;
    check("reset_ctrl", 32'(data_out), 32'h00);
    rd(A_IDX, "reset_idx");

    // Program entry 2 and look it up
    wsfr(A_IDX, 8'h02);
    wsfr(A_LO, 8'h34);
    wsfr(A_HI, 8'h12);
    cyc(1'b0, 1'b0, 8'h0, 8'h0, 1'b1, 2);
    check("t1_target", 32'(ecall_target), 32'h1234);
    check("t1_fault", 32'(ecall_fault), 32'h0);
    check("t1_ack", 32'(ecall_ack), 32'h1);
    cyc(1'b0, 1'b0, 8'h0, 8'h0, 1'b0, 0);
    check("t1_ack_drop", 32'(ecall_ack), 32'h0);

    // Lookup of an invalid entry
    cyc(1'b0, 1'b0, 8'h0, 8'h0, 1'b1, 1);
    check("t2_fault", 32'(ecall_fault), 32'h1);
    check("t2_target", 32'(ecall_target), 32'h0);

    // IDX change abandons a staged LO
    wsfr(A_IDX, 8'h00);
    wsfr(A_LO, 8'hAA);
    wsfr(A_IDX, 8'h03);
    wsfr(A_HI, 8'h55);
    rd_addr = A_CTRL; #1;
    check("t3_ctrl", 32'(data_out), 32'h80);
    rd(A_LO, "t3_lo");
    rd(A_HI, "t3_hi");
    wsfr(A_CTRL, 8'h80);
    rd_addr = A_CTRL; #1;
    check("t3_ctrl_clr", 32'(data_out), 32'h00);

    // Locked entry resists commit and invalidate
    wsfr(A_IDX, 8'h00);
    wsfr(A_LO, 8'hEF);
    wsfr(A_HI, 8'hBE);
    wsfr(A_CTRL, 8'h01);
    wsfr(A_LO, 8'h00);
    wsfr(A_HI, 8'h00);
    wsfr(A_CTRL, 8'h02);
    rd_addr = A_LO; #1;
    check("t4_lo", 32'(data_out), 32'hEF);
    rd_addr = A_HI; #1;
    check("t4_hi", 32'(data_out), 32'hBE);
    rd_addr = A_CTRL; #1;
    check("t4_ctrl", 32'(data_out), 32'h83);

    // Same-cycle commit forwarded into lookup
    wsfr(A_IDX, 8'h01);
    wsfr(A_LO, 8'h21);
    cyc(1'b1, 1'b0, A_HI, 8'h43, 1'b1, 1);
    check("t5_fwd", 32'(ecall_target), 32'h4321);
    check("t5_fault", 32'(ecall_fault), 32'h0);

    // Reset while staged with a lookup in flight
    wsfr(A_IDX, 8'h02);
    wsfr(A_LO, 8'h77);
    do_reset(1'b1);
    rd_addr = A_CTRL; #1;
    check("t6_ctrl", 32'(data_out), 32'h00);
    for (int i = 0; i < N; i++) begin
      wsfr(A_IDX, 8'(i));
      rd_addr = A_LO; #1;
      check("t6_lo", 32'(data_out), 32'h0);
      rd_addr = A_HI; #1;
      check("t6_hi", 32'(data_out), 32'h0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: a = A_IDX;
        1: a = A_LO;
        2: a = A_HI;
        3: a = A_CTRL;
        default: a = 8'($urandom);
      endcase
      d = 8'($urandom);
      if (a == A_CTRL && $urandom_range(0, 3) != 0) d[0] = 1'b0;
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1'($urandom));
      end else begin
        cyc($urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, a, d,
            1'($urandom), int'($urandom_range(0, N - 1)));
      end
      case ($urandom_range(0, 4))
        0: rd(A_IDX, "rnd_idx");
        1: rd(A_LO, "rnd_lo");
        2: rd(A_HI, "rnd_hi");
        3: rd(A_CTRL, "rnd_ctrl");
        default: rd(8'($urandom), "rnd_other");
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/oc8051_etr_bank.md
# oc8051_etr_bank

Multi-entry Ecall Target Register bank for the oc8051 secure-boot core: holds `N_ENTRIES` 16-bit ecall targets, programmed through four SFRs with atomic LO/HI commit, per-entry valid and lock bits, and a one-cycle lookup port used by the ecall decode logic to fetch the jump target for a numbered ecall. It sits on the SFR write bus next to the other SFR modules and feeds the PC-load mux in the ecall path.

## Interface
- `N_ENTRIES`, default 4: number of target entries; a power of two in the range 2..16. `IW = $clog2(N_ENTRIES)`.
- `SFR_IDX`, default `OC8051_SFR_ETR_IDX`: entry index select SFR address.
- `SFR_LO`, default `OC8051_SFR_ETR_LO`: low-byte staging SFR address.
- `SFR_HI`, default `OC8051_SFR_ETR_HI`: high-byte and commit SFR address.
- `SFR_CTRL`, default `OC8051_SFR_ETR_CTRL`: control/status SFR address.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `wr` in 1: SFR write strobe.
- `wr_bit` in 1: bit-addressed write; when 1 the block ignores the write.
- `wr_addr` in 8: SFR write address.
- `data_in` in 8: SFR write data.
- `rd_addr` in 8: SFR read address.
- `data_out` out 8: readback, combinational from `rd_addr`; 0 for addresses outside the block.
- `rd_hit` out 1: `rd_addr` matches one of the four SFRs.
- `ecall_req` in 1: lookup request.
- `ecall_idx` in IW: entry to look up.
- `ecall_ack` out 1: lookup result valid, one cycle after `ecall_req`.
- `ecall_target` out 16: looked-up target.
- `ecall_fault` out 1: looked-up entry is invalid; asserted only together with `ecall_ack`.

## Operation
- A byte write is qualified as `wr && !wr_bit && wr_addr == SFR_x`.
- **IDX write:** `idx <= data_in[IW-1:0]`; the upper bits are ignored. If the written value differs from the current `idx`, the staging FSM returns to IDLE.
- **Staging FSM:**
  - IDLE → STAGED on a LO write; `stage_lo <= data_in`. A LO write while STAGED overwrites `stage_lo` and stays in STAGED.
  - HI write while STAGED: if entry `idx` is unlocked, `entry[idx] <= {data_in, stage_lo}` and `valid[idx] <= 1`. If it is locked, there is no change and `err <= 1`. The FSM returns to IDLE in both cases.
  - HI write while IDLE: no entry change; `err <= 1`. A partial write never reaches an entry.
- **CTRL write:**
  - bit0 = 1: sets `lock[idx]`. Lock is sticky until reset.
  - bit1 = 1: clears `valid[idx]` if the entry is unlocked; otherwise `err <= 1`.
  - bit7 = 1: clears `err`. If bit7 is set in the same write that also raises an error, the set wins.
- **Readback:**
  - IDX: `{0, idx}`.
  - LO: `entry[idx][7:0]`.
  - HI: `entry[idx][15:8]`.
  - CTRL: `{err, 4'b0, fsm==STAGED, lock[idx], valid[idx]}`.
- **Lookup:** `ecall_req` registers the result for `ecall_idx`. It uses the post-write value: a HI commit or invalidate to the same entry in the same cycle is forwarded into the result. Back-to-back requests are accepted every cycle.
- **Reset values:**
  - all entries 0, `valid` 0, `lock` 0, `idx` 0, `stage_lo` 0, FSM IDLE, `err` 0.
  - outputs: `ecall_ack` 0, `ecall_target` 0, `ecall_fault` 0, `data_out` 0 for the reset-state CTRL read.

## Timing
- All register updates occur on the rising edge of `clk` following the qualified write.
- `ecall_ack`, `ecall_target` and `ecall_fault` are registered and valid exactly 1 cycle after `ecall_req`. When `ecall_req` was 0, `ecall_ack` is 0, and `ecall_target`/`ecall_fault` hold their last values.
- `data_out` reflects state as of the current cycle; writes become visible on the next cycle.
- `rst` asserted mid-sequence (STAGED, or a lookup in flight) discards everything: the next cycle shows reset values, and `ecall_ack` = 0 even if `ecall_req` was high in the reset cycle.
- Only one SFR write per cycle is possible, so there are no SFR-vs-SFR collisions. Lookup and SFR write in the same cycle are legal.

## Structure
- Shared package/defines: the four SFR address constants, CTRL bit positions (`ETR_CTRL_VALID=0`, `LOCK=1`, `STAGED=2`, `ERR=7`) and the FSM state encoding (IDLE=0, STAGED=1).
- One sub-module, `oc8051_etr_entry`: a 16-bit target with valid/lock, commit/invalidate/lock inputs and a locked-violation output. It is instantiated `N_ENTRIES` times under a generate loop.

## Test plan
- After reset, IDX=2, LO=0x34, HI=0x12, then lookup idx 2: `ecall_target`=0x1234 and `ecall_fault`=0 one cycle later, with `ecall_ack` high for exactly one cycle.
- Lookup idx 1 after reset: `ecall_ack`=1, `ecall_fault`=1, `ecall_target`=0x0000.
- LO=0xAA, then IDX changes 0→3, then HI=0x55: entry 3 is unchanged, CTRL read shows `err`=1 and STAGED=0; CTRL write 0x80 clears `err`.
- Program entry 0 = 0xBEEF, CTRL=0x01 (lock), then LO=0x00/HI=0x00 and CTRL=0x02: entry still reads 0xBEEF, `valid`=1, `err`=1.
- HI commit of 0x4321 to entry 1 in the same cycle as `ecall_req` with idx 1: next-cycle `ecall_target`=0x4321.
- `rst` asserted in the same cycle as `ecall_req` and while STAGED: next cycle `ecall_ack`=0, CTRL reads 0x00, and all entries read 0.
